// File: rtl/diram_arb_pkg.sv
// diram_arb_pkg: shared types and ids for the DiRAM port arbiter
package diram_arb_pkg;
  localparam int ARB_NUM_REQ = 4;
  localparam int DMA_ID = 0;
  localparam int LDST_ID = 1;
  localparam int MRC0_ID = 2;
  typedef enum logic {IDLE, BURST} arb_state_e;
  typedef logic [$clog2(ARB_NUM_REQ)-1:0] req_id_t;
  typedef struct packed {
    logic    vld;
    req_id_t id;
  } rd_tag_t;
endpackage

// File: rtl/diram_arb_rr_pick.sv
// diram_arb_rr_pick: combinational round-robin picker, searches from rr_ptr_i+1 upward with wrap
//   req_i    : request vector
//   rr_ptr_i : last served requester (lowest priority)
//   gnt_o    : chosen requester id (rr_ptr_i when nothing requests)
//   any_o    : at least one request present
module diram_arb_rr_pick
  import diram_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  req_id_t            rr_ptr_i,
  output req_id_t            gnt_o,
  output logic               any_o
);
  req_id_t idx;
  // Walk from farthest to nearest so the nearest valid requester after rr_ptr_i wins.
  always_comb begin
    any_o = |req_i;
    gnt_o = rr_ptr_i;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = req_id_t'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (req_i[idx]) gnt_o = idx;
    end
  end
endmodule

// File: rtl/diram_port_arb.sv
// diram_port_arb: round-robin, burst-locked arbiter sharing one DiRAM port, with read-return steering
//   req_*  : per-requester valid/ready beats (packed address/data buses)
//   rsp_*  : one-hot read-return strobe and shared read data
//   mem_*  : DiRAM access port, mem_rdata arrives RD_LAT cycles after an accepted read
//   busy   : grant held or any read still in flight
module diram_port_arb
  import diram_arb_pkg::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 64,
  parameter int RD_LAT    = 3,
  parameter int MAX_BURST = 8
) (
  input  logic                        clk,
  input  logic                        reset_poweron_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  input  logic                        mem_ready,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);
  localparam int BCW = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  req_id_t          gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, pick_id;
  logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
  rd_tag_t          pipe_q [RD_LAT];
  rd_tag_t          head;
  logic             pick_any, in_burst, g_valid, g_we, g_last, beat, rel, pipe_any;
  logic [ADDR_W-1:0] addr_a  [NUM_REQ];
  logic [DATA_W-1:0] wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  diram_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (pick_id),
    .any_o    (pick_any)
  );

  assign in_burst = state_q == BURST;
  assign g_valid  = req_valid[gnt_q];
  assign g_we     = req_we[gnt_q];
  assign g_last   = req_last[gnt_q];
  assign beat     = in_burst & g_valid & mem_ready;
  // A stalled beat (valid, not ready) neither counts nor releases; only a dropped valid does.
  assign rel      = in_burst & (~g_valid | (beat & (g_last | beat_cnt_q == BCW'(MAX_BURST - 1))));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat ? beat_cnt_q + 1'b1 : beat_cnt_q;
    if (!in_burst && pick_any) begin
      state_d = BURST;
      gnt_d   = pick_id;
    end
    if (rel) begin
      state_d    = IDLE;
      rr_ptr_d   = gnt_q;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= req_id_t'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Fixed-latency return tracker: the tag reaches the head exactly when mem_rdata is valid.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{vld: beat & ~g_we, id: gnt_q};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    pipe_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) pipe_any = pipe_any | pipe_q[i].vld;
  end

  assign head      = pipe_q[RD_LAT-1];
  assign rsp_valid = head.vld ? NUM_REQ'(1) << head.id : '0;
  assign rsp_data  = head.vld ? mem_rdata : '0;
  assign req_ready = (in_burst & mem_ready) ? NUM_REQ'(1) << gnt_q : '0;
  assign mem_en    = beat;
  assign mem_we    = in_burst & g_we;
  assign mem_addr  = in_burst ? addr_a[gnt_q] : '0;
  assign mem_wdata = in_burst ? wdata_a[gnt_q] : '0;
  assign busy      = in_burst | pipe_any;
endmodule

// File: tb/tb_diram_port_arb.sv
// tb_diram_port_arb: scoreboard bench for the DiRAM port arbiter
module tb_diram_port_arb;
  localparam int N = 4, AW = 24, DW = 64, LAT = 3;

  typedef struct {
    logic          we;
    logic          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } beat_t;
  typedef struct { int id; int due; } exp_t;
  typedef struct { int id; int cyc; } acc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready, req_we = '0, req_last = '0, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0]   rsp_data, mem_wdata, mem_rdata = '0;
  logic [AW-1:0]   mem_addr;
  logic            mem_ready = 1'b1, mem_en, mem_we, busy;

  beat_t  beats [N][$];
  exp_t   sb[$];
  acc_t   acc_log[$];
  int     rsp_log[$];
  logic [N-1:0] acc_flag = '0;
  int cyc = 0, n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  diram_port_arb dut (
    .clk(clk), .reset_poweron_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_last(req_last),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_ready(mem_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] rd_pat(input int c);
    return {32'hD1A0_0000 ^ 32'(c), 32'(c) * 32'h9E37_79B9};
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (beats[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Memory model and requester drivers: each requester presents the head of its beat queue.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    mem_rdata = rd_pat(cyc);
    for (int i = 0; i < N; i++) begin
      if (acc_flag[i] && beats[i].size() > 0) beats[i].delete(0);
      acc_flag[i] = 1'b0;
      if (beats[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_we[i]    = beats[i][0].we;
        req_last[i]  = beats[i][0].last;
        req_addr[i*AW +: AW]  = beats[i][0].addr;
        req_wdata[i*DW +: DW] = beats[i][0].wdata;
      end else begin
        req_valid[i] = 1'b0;
        req_we[i]    = 1'b0;
        req_last[i]  = 1'b0;
        req_addr[i*AW +: AW]  = '0;
        req_wdata[i*DW +: DW] = '0;
      end
    end
  end

  // Monitor: checks every accepted beat against the issuing requester and every read return.
  logic [N-1:0] acc;
  int gi;
  exp_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      acc = req_valid & req_ready;
      n_chk++;
      if (acc == '0) begin
        if (mem_en !== 1'b0) $display("FAIL idle_mem_en: got %b expected 0 at cycle %0d", mem_en, cyc);
        else n_pass++;
      end else begin
        gi = 0;
        for (int i = 0; i < N; i++) if (acc[i]) gi = i;
        if (!$onehot(acc) || beats[gi].size() == 0 || mem_en !== 1'b1 || mem_we !== beats[gi][0].we ||
            mem_addr !== beats[gi][0].addr || (beats[gi][0].we && mem_wdata !== beats[gi][0].wdata))
          $display("FAIL beat_mux: acc %b en %b we %b addr %h at cycle %0d", acc, mem_en, mem_we, mem_addr, cyc);
        else begin
          n_pass++;
          acc_log.push_back('{gi, cyc});
          acc_flag[gi] = 1'b1;
          if (!beats[gi][0].we) sb.push_back('{gi, cyc + LAT});
        end
      end
      n_chk++;
      if (rsp_valid !== '0) begin
        if (sb.size() == 0) $display("FAIL rsp_unexpected: got %b expected 0000 at cycle %0d", rsp_valid, cyc);
        else begin
          e = sb.pop_front();
          rsp_log.push_back(e.id);
          if (rsp_valid !== (4'b1 << e.id) || e.due != cyc || rsp_data !== rd_pat(cyc))
            $display("FAIL rsp: got %b/%h at %0d expected %b/%h at %0d", rsp_valid, rsp_data, cyc,
                     4'b1 << e.id, rd_pat(e.due), e.due);
          else n_pass++;
        end
      end else begin
        if (rsp_data !== '0 || (sb.size() > 0 && sb[0].due <= cyc))
          $display("FAIL rsp_missing: got %b/%h at cycle %0d", rsp_valid, rsp_data, cyc);
        else n_pass++;
      end
    end
  end

  task automatic push_beat(input int id, input logic we, input logic last, input int addr);
    beats[id].push_back('{we, last, AW'(addr), {32'hCAFE_0000 | 32'(addr), 32'(id)}});
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((pending() || sb.size() > 0 || busy) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    n_chk++;
    if (n >= budget) $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", tag, n);
    else n_pass++;
    @(negedge clk); #1;
  endtask

  task automatic check_acc(input string tag, input int idx, input int id, input int c);
    n_chk++;
    if (idx >= acc_log.size()) $display("FAIL %s: beat %0d missing, expected id %0d", tag, idx, id);
    else if (acc_log[idx].id != id || (c >= 0 && acc_log[idx].cyc != c))
      $display("FAIL %s: got id %0d cyc %0d expected id %0d cyc %0d", tag, acc_log[idx].id, acc_log[idx].cyc, id, c);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata, busy} !== '0)
      $display("FAIL reset_outputs: got ready %b rsp %b en %b busy %b expected all 0", req_ready, rsp_valid, mem_en, busy);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if (busy !== 1'b0 || req_ready !== '0) $display("FAIL reset_idle: got busy %b ready %b expected 0", busy, req_ready);
    else n_pass++;
  endtask

  task automatic test_round_robin;
    int base = acc_log.size();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push_beat(i, 1'b1, 1'b1, 16 * i + k);
    wait_done("rr", 100);
    for (int j = 0; j < 8; j++)
      check_acc("rr_order", base + j, j % N, j == 0 ? -1 : acc_log[base].cyc + 2 * j);
  endtask

  task automatic test_single_read;
    int base = acc_log.size(), rbase = rsp_log.size(), c0 = cyc;
    for (int k = 0; k < 3; k++) push_beat(1, 1'b0, k == 2, 'h100 + k);
    wait_done("single", 60);
    for (int k = 0; k < 3; k++) check_acc("single_beat", base + k, 1, c0 + 2 + k);
    n_chk++;
    if (rsp_log.size() != rbase + 3) $display("FAIL single_rsp_count: got %0d expected 3", rsp_log.size() - rbase);
    else n_pass++;
  endtask

  task automatic test_burst_cap;
    int base = acc_log.size();
    for (int k = 0; k < 12; k++) push_beat(0, 1'b1, 1'b0, 'h200 + k);
    push_beat(1, 1'b1, 1'b1, 'h2F0);
    wait_done("cap", 120);
    for (int j = 0; j < 8; j++) check_acc("cap_first8", base + j, 0, j == 0 ? -1 : acc_log[base].cyc + j);
    check_acc("cap_pending", base + 8, 1, acc_log[base].cyc + 9);
    for (int j = 9; j < 13; j++) check_acc("cap_rest", base + j, 0, acc_log[base].cyc + 11 + (j - 9));
  endtask

  task automatic test_stall;
    int base = acc_log.size(), n = 0, k;
    for (int j = 0; j < 4; j++) push_beat(1, 1'b0, j == 3, 'h300 + j);
    while (acc_log.size() < base + 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    n_chk++;
    if (n >= 50) $display("FAIL stall_start_timeout: got %0d beats expected 2", acc_log.size() - base);
    else n_pass++;
    k = cyc;
    @(posedge clk); #2;
    mem_ready = 1'b0;
    repeat (5) begin
      @(negedge clk); #1;
      n_chk++;
      if (req_ready !== '0 || mem_addr !== 24'h302 || mem_we !== 1'b0 || busy !== 1'b1)
        $display("FAIL stall_hold: got ready %b addr %h we %b busy %b expected 0000 000302 0 1", req_ready, mem_addr, mem_we, busy);
      else n_pass++;
    end
    @(posedge clk); #2;
    mem_ready = 1'b1;
    wait_done("stall", 60);
    check_acc("stall_resume3", base + 2, 1, k + 6);
    check_acc("stall_resume4", base + 3, 1, k + 7);
  endtask

  task automatic test_interleave;
    int base = acc_log.size(), rbase = rsp_log.size();
    push_beat(2, 1'b0, 1'b1, 'h400);
    push_beat(3, 1'b0, 1'b1, 'h410);
    wait_done("ilv", 60);
    check_acc("ilv_req2", base, 2, -1);
    check_acc("ilv_req3", base + 1, 3, base < acc_log.size() ? acc_log[base].cyc + 2 : -1);
    n_chk++;
    if (rsp_log.size() != rbase + 2 || rsp_log[rbase] != 2 || rsp_log[rbase + 1] != 3)
      $display("FAIL ilv_rsp_order: got %0d returns expected ids 2 then 3", rsp_log.size() - rbase);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int base = acc_log.size(), n = 0;
    for (int j = 0; j < 4; j++) push_beat(1, 1'b0, j == 3, 'h500 + j);
    while (acc_log.size() < base + 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata, busy} !== '0 || n >= 50)
      $display("FAIL mid_reset_outputs: got ready %b rsp %b en %b busy %b expected all 0", req_ready, rsp_valid, mem_en, busy);
    else n_pass++;
    for (int i = 0; i < N; i++) beats[i].delete();
    sb.delete();
    acc_flag = '0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk); #1;
      n_chk++;
      if (rsp_valid !== '0 || busy !== 1'b0) $display("FAIL post_reset_quiet: got rsp %b busy %b expected 0000 0", rsp_valid, busy);
      else n_pass++;
    end
    base = acc_log.size();
    push_beat(2, 1'b1, 1'b1, 'h600);
    push_beat(0, 1'b1, 1'b1, 'h610);
    wait_done("post_reset", 60);
    check_acc("post_reset_first", base, 0, -1);
    check_acc("post_reset_second", base + 1, 2, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_burst_cap();
    test_stall();
    test_interleave();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
